// File: rtl/machine_irq_arbiter.sv
// Machine-mode interrupt arbiter: MIP image, MIE gating, fixed priority, one-at-a-time service.
// Optional MACHINE_IRQ_EXT_SYNC_EN adds a 2-flop synchronizer on ext_irq.
module machine_irq_arbiter #(
    parameter int XLEN     = 32,
    parameter bit EXT_EDGE = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sync_reset,
    input  logic            timer_triggered,
    input  logic            ext_irq,
    input  logic            sw_irq_set,
    input  logic            sw_irq_clr,
    input  logic [XLEN-1:0] mie,
    input  logic            mstatus_mie,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_cause,
    input  logic            irq_ack,
    input  logic            mret,
    output logic [XLEN-1:0] mip_read_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_IN_SVC,
        S_HOLDOFF
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_load;
    logic            w_ext;
    logic            r_ext_d;
    logic            w_ext_rise;
    logic            r_mtip;
    logic            r_msip;
    logic            r_meip;
    logic            w_ack;
    logic            w_meip_clr;
    logic [3:0]      w_code;
    logic [XLEN-1:0] w_en;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] r_cause;

`ifdef MACHINE_IRQ_EXT_SYNC_EN
    logic r_ext_s1;
    logic r_ext_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ext_s1 <= 1'b0;
            r_ext_s2 <= 1'b0;
        end else if (sync_reset) begin
            r_ext_s1 <= 1'b0;
            r_ext_s2 <= 1'b0;
        end else begin
            r_ext_s1 <= ext_irq;
            r_ext_s2 <= r_ext_s1;
        end
    end

    assign w_ext = r_ext_s2;
`else
    assign w_ext = ext_irq;
`endif

    assign w_ext_rise = w_ext & ~r_ext_d;
    assign w_ack      = irq_ack && (r_state == S_REQ);
    assign w_meip_clr = w_ack && (r_cause[3:0] == 4'd11);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ext_d <= 1'b0;
            r_mtip  <= 1'b0;
            r_msip  <= 1'b0;
            r_meip  <= 1'b0;
        end else if (sync_reset) begin
            r_ext_d <= 1'b0;
            r_mtip  <= 1'b0;
            r_msip  <= 1'b0;
            r_meip  <= 1'b0;
        end else begin
            r_ext_d <= w_ext;
            r_mtip  <= timer_triggered;
            if (sw_irq_clr)
                r_msip <= 1'b0;
            else if (sw_irq_set)
                r_msip <= 1'b1;
            // A fresh edge outranks the ack that retires the previous one
            if (EXT_EDGE) begin
                if (w_ext_rise)
                    r_meip <= 1'b1;
                else if (w_meip_clr)
                    r_meip <= 1'b0;
            end else begin
                r_meip <= w_ext;
            end
        end
    end

    always_comb begin
        mip_read_data     = '0;
        mip_read_data[3]  = r_msip;
        mip_read_data[7]  = r_mtip;
        mip_read_data[11] = r_meip;
    end

    assign w_en = mip_read_data & mie;

    always_comb begin
        w_code = 4'd0;
        if (w_en[11])
            w_code = 4'd11;
        else if (w_en[3])
            w_code = 4'd3;
        else if (w_en[7])
            w_code = 4'd7;
    end

    always_comb begin
        w_cause           = '0;
        w_cause[XLEN-1]   = 1'b1;
        w_cause[3:0]      = w_code;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (mstatus_mie && (|w_en)) begin
                    w_state_nxt = S_REQ;
                    w_load      = 1'b1;
                end
            end
            S_REQ: begin
                if (irq_ack)
                    w_state_nxt = S_IN_SVC;
            end
            S_IN_SVC: begin
                if (mret)
                    w_state_nxt = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cause <= '0;
        end else if (sync_reset) begin
            r_state <= S_IDLE;
            r_cause <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load)
                r_cause <= w_cause;
        end
    end

    assign irq_req   = (r_state == S_REQ);
    assign irq_cause = r_cause;

endmodule

// File: tb/tb_machine_irq_arbiter.sv
// Scoreboarded bench for machine_irq_arbiter: expected causes queued at stimulus time.
module tb_machine_irq_arbiter;

`ifdef MACHINE_IRQ_EXT_SYNC_EN
    localparam int EXT_LAT = 3;
`else
    localparam int EXT_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sync_reset;
    logic        timer_triggered;
    logic        ext_irq;
    logic        sw_irq_set;
    logic        sw_irq_clr;
    logic [31:0] mie;
    logic        mstatus_mie;
    logic        irq_req;
    logic [31:0] irq_cause;
    logic        irq_ack;
    logic        mret;
    logic [31:0] mip_read_data;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    machine_irq_arbiter #(.XLEN(32), .EXT_EDGE(1'b1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sync_reset     (sync_reset),
        .timer_triggered(timer_triggered),
        .ext_irq        (ext_irq),
        .sw_irq_set     (sw_irq_set),
        .sw_irq_clr     (sw_irq_clr),
        .mie            (mie),
        .mstatus_mie    (mstatus_mie),
        .irq_req        (irq_req),
        .irq_cause      (irq_cause),
        .irq_ack        (irq_ack),
        .mret           (mret),
        .mip_read_data  (mip_read_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_req(input string tag, input int budget);
        logic [31:0] e;
        int n;
        n = 0;
        while (!irq_req && n < budget) begin
            tick();
            n++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (!irq_req)
            chk({tag, "_timeout"}, {31'b0, irq_req}, 32'd1);
        else
            chk(tag, irq_cause, e);
    endtask

    task automatic svc();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        mret    = 1'b1;
        tick();
        mret    = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        reset_n         = 1'b0;
        sync_reset      = 1'b0;
        timer_triggered = 1'b0;
        ext_irq         = 1'b0;
        sw_irq_set      = 1'b0;
        sw_irq_clr      = 1'b0;
        mie             = 32'h0;
        mstatus_mie     = 1'b0;
        irq_ack         = 1'b0;
        mret            = 1'b0;
        tick();
        tick();
        chk("rst_req", {31'b0, irq_req}, 32'd0);
        chk("rst_cause", irq_cause, 32'd0);
        chk("rst_mip", mip_read_data, 32'd0);
        reset_n = 1'b1;
        tick();

        // timer interrupt
        mie             = 32'h80;
        mstatus_mie     = 1'b1;
        timer_triggered = 1'b1;
        tick();
        chk("tmr_mip", mip_read_data, 32'h80);
        chk("tmr_lat", {31'b0, irq_req}, 32'd0);
        exp_q.push_back(32'h8000_0007);
        tick();
        sb_req("tmr_req", 0);
        timer_triggered = 1'b0;
        tick();
        tick();
        chk("commit_mip", mip_read_data, 32'h0);
        chk("commit_req", {31'b0, irq_req}, 32'd1);
        chk("commit_cause", irq_cause, 32'h8000_0007);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("tmr_ack", {31'b0, irq_req}, 32'd0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        tick();

        // priority, all three land together
        mie     = 32'h888;
        ext_irq = 1'b1;
        repeat (EXT_LAT - 1) tick();
        timer_triggered = 1'b1;
        sw_irq_set      = 1'b1;
        tick();
        sw_irq_set = 1'b0;
        chk("prio_mip", mip_read_data, 32'h888);
        chk("prio_lat", {31'b0, irq_req}, 32'd0);
        exp_q.push_back(32'h8000_000B);
        exp_q.push_back(32'h8000_0003);
        tick();
        sb_req("prio_mei", 0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("prio_ack_mip", mip_read_data, 32'h088);
        repeat (3) tick();
        chk("insvc_noreq", {31'b0, irq_req}, 32'd0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("holdoff_noreq", {31'b0, irq_req}, 32'd0);
        tick();
        chk("idle_noreq", {31'b0, irq_req}, 32'd0);
        tick();
        sb_req("b2b_msi", 0);
        sw_irq_clr = 1'b1;
        tick();
        sw_irq_clr = 1'b0;
        svc();
        exp_q.push_back(32'h8000_0007);
        sb_req("prio_mti", 3);
        timer_triggered = 1'b0;
        ext_irq         = 1'b0;
        svc();
        repeat (4) tick();
        chk("prio_idle_req", {31'b0, irq_req}, 32'd0);

        // gating by mstatus_mie
        mstatus_mie = 1'b0;
        mie         = 32'h8;
        sw_irq_set  = 1'b1;
        tick();
        sw_irq_set = 1'b0;
        repeat (4) tick();
        chk("gate_off_req", {31'b0, irq_req}, 32'd0);
        chk("gate_off_mip", mip_read_data, 32'h8);
        mstatus_mie = 1'b1;
        exp_q.push_back(32'h8000_0003);
        tick();
        sb_req("gate_on", 0);
        sw_irq_clr = 1'b1;
        tick();
        sw_irq_clr = 1'b0;
        svc();

        // MSIP set and clear together
        mstatus_mie = 1'b0;
        sw_irq_set  = 1'b1;
        tick();
        sw_irq_set = 1'b0;
        chk("msip_set", mip_read_data, 32'h8);
        sw_irq_set = 1'b1;
        sw_irq_clr = 1'b1;
        tick();
        sw_irq_set = 1'b0;
        sw_irq_clr = 1'b0;
        chk("msip_clr_wins", mip_read_data, 32'h0);
        mstatus_mie = 1'b1;

        // MEIP latency and rise coinciding with ack
        mie     = 32'h800;
        ext_irq = 1'b1;
        n = 0;
        while (!mip_read_data[11] && n < 8) begin
            tick();
            n++;
        end
        chk("ext_lat", n, EXT_LAT);
        exp_q.push_back(32'h8000_000B);
        tick();
        sb_req("meip_req", 0);
        ext_irq = 1'b0;
        repeat (4) tick();
        ext_irq = 1'b1;
        repeat (EXT_LAT - 1) tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("meip_set_wins", mip_read_data, 32'h800);
        chk("meip_ack_req", {31'b0, irq_req}, 32'd0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        tick();
        exp_q.push_back(32'h8000_000B);
        sb_req("meip_again", 2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("meip_ack_clr", mip_read_data, 32'h0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        tick();
        ext_irq = 1'b0;
        repeat (4) tick();

        // resets mid-operation
        mie             = 32'h80;
        timer_triggered = 1'b1;
        exp_q.push_back(32'h8000_0007);
        sb_req("rst_pre", 4);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("mret_ignored", {31'b0, irq_req}, 32'd1);
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        chk("srst_req", {31'b0, irq_req}, 32'd0);
        chk("srst_mip", mip_read_data, 32'h0);
        chk("srst_cause", irq_cause, 32'h0);
        exp_q.push_back(32'h8000_0007);
        sb_req("srst_idle", 3);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_req", {31'b0, irq_req}, 32'd0);
        chk("arst_mip", mip_read_data, 32'h0);
        chk("arst_cause", irq_cause, 32'h0);
        #2;
        reset_n = 1'b1;
        tick();
        exp_q.push_back(32'h8000_0007);
        sb_req("arst_idle", 3);
        timer_triggered = 1'b0;
        svc();
        chk("sb_drain", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
